periodic_sampler: RTL and testbench
===================================

# periodic_sampler

Periodic capture stage that sits directly upstream of a bank of `register` instances. It generates a one-cycle `tick` strobe every `PERIOD` clock cycles while `run` is high, samples `d` on each tick into an output holding register, and presents the sample downstream with a valid/ready handshake. A sample that is overwritten before it is consumed raises a sticky overrun flag.

## Interface
- `W`, default 8: sample width in bits.
- `PERIOD`, default 3: cycles between ticks. Legal values are 1 to 65535.
- `CW`, default `max(1, $clog2(PERIOD))`: phase-counter width. Derived; do not override.

- `clk` input 1: clock; all state updates on the rising edge.
- `rst_b` input 1: reset, asynchronous, active-low.
- `run` input 1: enables the phase counter. When low, the counter is held at 0.
- `d` input W: data sampled on `tick`.
- `tick` output 1: combinational strobe, `run & (cnt == PERIOD-1)`.
- `out_data` output W: held sample.
- `out_valid` output 1: `out_data` holds an unconsumed sample.
- `out_ready` input 1: downstream accepts the sample.
- `overrun` output 1: sticky; set when an unconsumed sample is overwritten.
- `clr_ovr` input 1: synchronous clear of `overrun` (and of `drop_cnt` when compiled in).

## Operation
**Phase counter `cnt` (CW bits)**
- `run` low: `cnt` ← 0.
- `run` high and `cnt == PERIOD-1`: `tick` = 1 and `cnt` ← 0.
- Otherwise: `cnt` ← `cnt + 1`. The counter never exceeds `PERIOD-1`.
- `PERIOD = 1`: `tick` = `run` on every cycle.

**Output holding register**
- On `tick`: `out_data` ← `d` and `out_valid` ← 1.
- On `out_valid & out_ready` with no `tick`: `out_valid` ← 0. `out_data` keeps its last value.
- `tick`, `out_valid` and `out_ready` all high in the same cycle: the old sample transfers, the new sample loads, and `out_valid` stays 1. This is not an overrun.
- `tick` with `out_valid & ~out_ready`: the new sample overwrites the old one and `overrun` ← 1.
- `overrun` is cleared only by `clr_ovr` or reset.
- `clr_ovr` and a new overrun in the same cycle: set wins, so `overrun` = 1.
- `run` falling does not affect a pending sample; it stays valid until accepted.

**Reset values**
- `cnt` = 0, `out_data` = 0, `out_valid` = 0, `overrun` = 0.
- `tick` = 0, because `cnt` = 0 ≠ `PERIOD-1` for `PERIOD` > 1.
- With `PERIOD = 1`, `tick` follows `run` even during reset.
- Reset asserted mid-operation discards any pending sample immediately (asynchronous).

## Timing
- First `tick` occurs in the PERIOD-th cycle in which `run` is sampled high. For example, `PERIOD = 3` gives `tick` in cycle 3 of `run`.
- Tick-to-valid latency is 1 cycle: `out_valid` and `out_data` update on the rising edge where `tick` = 1.
- Sustained throughput is one sample per `PERIOD` cycles. With `out_ready` tied high, `out_valid` is a 1-cycle pulse, except when `PERIOD = 1`, where it stays constantly high.
- `out_data` and `out_valid` are registered. `tick` is combinational from `run` and `cnt`.
- `out_ready` has no combinational path to any output.

## Configuration
- Macro: `PERIODIC_SAMPLER_DROPCNT_EN`.
- Defined:
  - Adds output port `drop_cnt` [7:0], reset value 0.
  - `drop_cnt` increments on every overrun event and saturates at 255.
  - `clr_ovr` clears it to 0. If `clr_ovr` coincides with an overrun, `drop_cnt` becomes 1.
- Undefined:
  - The port and its logic are absent.
  - Only the sticky `overrun` flag reports drops.

## Test plan
- **Reset and first tick.** `PERIOD = 3`, `run` = 1 from cycle 1, `d` = 0xA5, `out_ready` = 0 → `tick` high in cycle 3 only; `out_valid` = 1 and `out_data` = 0xA5 from cycle 4; `overrun` = 0.
- **Streaming.** `out_ready` = 1, `d` incrementing per cycle → one transfer every 3 cycles, each carrying the `d` value present at its tick; `out_valid` is a 1-cycle pulse; no overrun.
- **Overrun.** `out_ready` = 0 across two ticks with `d` = 0x11 then 0x22 → `out_data` = 0x22 and `overrun` = 1. `clr_ovr` pulse → `overrun` = 0. With the macro defined, `drop_cnt` = 1, then 0 after `clr_ovr`.
- **Coincident tick and accept.** `out_valid` = 1 with `out_ready` = 1 in a tick cycle → old sample accepted, new sample loaded, `out_valid` stays 1, `overrun` stays 0.
- **Run pause.** Drop `run` at `cnt` = 1 → `cnt` = 0 and no tick; the pending sample stays valid. Restart `run` → the next tick comes a full 3 cycles later.
- **Async reset mid-stream, plus `PERIOD = 1`.** Assert `rst_b` = 0 mid-stream → all outputs go to 0 without a clock edge. Repeat with `PERIOD = 1` → `tick` = `run` on every cycle and `out_data` tracks `d` with 1-cycle delay when `out_ready` = 1.

Source files
------------

// File: rtl/periodic_sampler.sv
// Periodic capture stage: ticks every PERIOD cycles while run is high and holds the
// sample behind a valid/ready handshake. Optional PERIODIC_SAMPLER_DROPCNT_EN adds drop_cnt.
module periodic_sampler #(
    parameter int W      = 8,
    parameter int PERIOD = 3,
    parameter int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         run,
    input  logic [W-1:0] d,
    output logic         tick,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         overrun,
    input  logic         clr_ovr
`ifdef PERIODIC_SAMPLER_DROPCNT_EN
    ,
    output logic [7:0]   drop_cnt
`endif
);

    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_reg, cnt_next;
    logic [W-1:0]  data_reg, data_next;
    logic          valid_reg, valid_next;
    logic          ovr_reg, ovr_next;
    logic          at_last;
    logic          ovr_evt;

    assign at_last = (cnt_reg == CNT_LAST);
    assign tick    = run & at_last;
    // A simultaneous accept drains the old sample, so only an unaccepted one is lost.
    assign ovr_evt = tick & valid_reg & ~out_ready;

    always_comb begin
        cnt_next   = '0;
        data_next  = data_reg;
        valid_next = valid_reg;
        if (run && !at_last) begin
            cnt_next = cnt_reg + CW'(1);
        end
        if (tick) begin
            data_next  = d;
            valid_next = 1'b1;
        end else if (valid_reg && out_ready) begin
            valid_next = 1'b0;
        end
        ovr_next = ovr_evt | (ovr_reg & ~clr_ovr);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_reg   <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            ovr_reg   <= ovr_next;
        end
    end

    assign out_data  = data_reg;
    assign out_valid = valid_reg;
    assign overrun   = ovr_reg;

`ifdef PERIODIC_SAMPLER_DROPCNT_EN
    logic [7:0] drop_reg, drop_next;

    // Set beats clear: an overrun coinciding with clr_ovr restarts the count at 1.
    always_comb begin
        drop_next = drop_reg;
        if (ovr_evt) begin
            if (clr_ovr) begin
                drop_next = 8'd1;
            end else if (drop_reg != 8'hFF) begin
                drop_next = drop_reg + 8'd1;
            end
        end else if (clr_ovr) begin
            drop_next = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            drop_reg <= 8'd0;
        end else begin
            drop_reg <= drop_next;
        end
    end

    assign drop_cnt = drop_reg;
`endif

endmodule

// File: tb/tb_periodic_sampler.sv
// Bench for periodic_sampler: PERIOD=3 and PERIOD=1 instances share stimulus and are
// checked every cycle against a run-length/modulo reference model.
module tb_periodic_sampler;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       run;
    logic [7:0] d;
    logic       out_ready;
    logic       clr_ovr;

    logic       tick_o  [2];
    logic [7:0] data_o  [2];
    logic       valid_o [2];
    logic       ovr_o   [2];
`ifdef PERIODIC_SAMPLER_DROPCNT_EN
    logic [7:0] drop_o  [2];
`endif

    int errors = 0;
    int checks = 0;

    // Reference state: k = consecutive run-high cycles seen so far.
    int         per     [2] = '{3, 1};
    int         k       [2];
    bit         m_valid [2];
    logic [7:0] m_data  [2];
    bit         m_ovr   [2];
    int         m_drop  [2];

    always #5 clk = ~clk;

    periodic_sampler #(.W(8), .PERIOD(3)) dut3 (
        .clk(clk), .rst_b(rst_b), .run(run), .d(d),
        .tick(tick_o[0]), .out_data(data_o[0]), .out_valid(valid_o[0]),
        .out_ready(out_ready), .overrun(ovr_o[0]), .clr_ovr(clr_ovr)
`ifdef PERIODIC_SAMPLER_DROPCNT_EN
        , .drop_cnt(drop_o[0])
`endif
    );

    periodic_sampler #(.W(8), .PERIOD(1)) dut1 (
        .clk(clk), .rst_b(rst_b), .run(run), .d(d),
        .tick(tick_o[1]), .out_data(data_o[1]), .out_valid(valid_o[1]),
        .out_ready(out_ready), .overrun(ovr_o[1]), .clr_ovr(clr_ovr)
`ifdef PERIODIC_SAMPLER_DROPCNT_EN
        , .drop_cnt(drop_o[1])
`endif
    );

    task automatic chk(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s P=%0d got=%0h exp=%0h", tag, per[i], got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            k[i] = 0; m_valid[i] = 0; m_data[i] = 8'h00; m_ovr[i] = 0; m_drop[i] = 0;
        end
    endtask

    // One clock cycle: drive at negedge, check, advance the model, pass the posedge.
    task automatic step(input bit rb, input bit r, input logic [7:0] dv, input bit rdy, input bit clr);
        bit exp_tick, evt;
        @(negedge clk);
        rst_b = rb; run = r; d = dv; out_ready = rdy; clr_ovr = clr;
        if (!rb) model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
            exp_tick = r && (((k[i] + 1) % per[i]) == 0);
            chk("tick", i, 32'(tick_o[i]), 32'(exp_tick));
            chk("out_valid", i, 32'(valid_o[i]), 32'(m_valid[i]));
            chk("out_data", i, 32'(data_o[i]), 32'(m_data[i]));
            chk("overrun", i, 32'(ovr_o[i]), 32'(m_ovr[i]));
`ifdef PERIODIC_SAMPLER_DROPCNT_EN
            chk("drop_cnt", i, 32'(drop_o[i]), 32'(m_drop[i]));
`endif
            if (rb) begin
                k[i] = r ? k[i] + 1 : 0;
                evt = exp_tick && m_valid[i] && !rdy;
                if (exp_tick) begin
                    m_data[i] = dv; m_valid[i] = 1;
                end else if (m_valid[i] && rdy) begin
                    m_valid[i] = 0;
                end
                m_ovr[i] = evt || (m_ovr[i] && !clr);
                if (evt) m_drop[i] = clr ? 1 : ((m_drop[i] < 255) ? m_drop[i] + 1 : 255);
                else if (clr) m_drop[i] = 0;
            end
        end
        @(posedge clk);
    endtask

    initial begin
        logic [7:0] cnt_d;
        rst_b = 1'b0; run = 1'b0; d = 8'h00; out_ready = 1'b0; clr_ovr = 1'b0;
        model_reset();

        // Reset state
        step(0, 0, 8'h00, 0, 0);
        step(0, 1, 8'h00, 0, 0);

        // First tick: run from cycle 1, d=A5, not ready
        for (int c = 0; c < 4; c++) step(1, 1, 8'hA5, 0, 0);
        step(1, 0, 8'h00, 1, 1);

        // Streaming with incrementing d
        cnt_d = 8'h40;
        for (int c = 0; c < 10; c++) begin
            step(1, 1, cnt_d, 1, 0);
            cnt_d++;
        end
        step(1, 0, 8'h00, 1, 0);

        // Overrun across two ticks, then clear
        for (int c = 0; c < 3; c++) step(1, 1, 8'h11, 0, 0);
        for (int c = 0; c < 3; c++) step(1, 1, 8'h22, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 0, 1);
        step(1, 0, 8'h00, 1, 0);

        // Coincident tick and accept
        for (int c = 0; c < 3; c++) step(1, 1, 8'h33, 0, 0);
        step(1, 1, 8'h44, 0, 0);
        step(1, 1, 8'h44, 0, 0);
        step(1, 1, 8'h55, 1, 0);
        step(1, 1, 8'h66, 0, 0);

        // Run pause at cnt=1, then restart
        step(1, 0, 8'h00, 0, 0);
        step(1, 1, 8'h77, 0, 0);
        step(1, 0, 8'h78, 0, 0);
        step(1, 0, 8'h79, 0, 0);
        for (int c = 0; c < 4; c++) step(1, 1, 8'h80 + 8'(c), 0, 0);
        step(1, 0, 8'h00, 0, 1);

        // Overrun coinciding with clr_ovr
        for (int c = 0; c < 6; c++) step(1, 1, 8'h90 + 8'(c), 0, (c == 5));

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            step(1, ($urandom_range(0, 7) != 0), 8'($urandom), $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 15) == 0));
        end

        // Async reset mid-stream with a pending sample
        for (int c = 0; c < 4; c++) step(1, 1, 8'hC3, 0, 0);
        #2;
        rst_b = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("async_valid", i, 32'(valid_o[i]), 32'd0);
            chk("async_data", i, 32'(data_o[i]), 32'd0);
            chk("async_ovr", i, 32'(ovr_o[i]), 32'd0);
        end
        chk("async_tick", 0, 32'(tick_o[0]), 32'd0);
        chk("async_tick", 1, 32'(tick_o[1]), 32'(run));
        model_reset();
        step(0, 1, 8'h00, 1, 0);
        cnt_d = 8'hE0;
        for (int c = 0; c < 8; c++) begin
            step(1, 1, cnt_d, 1, 0);
            cnt_d++;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
